// File: rtl/h_bdy_fe_mc.sv
// h_bdy_fe_mc: multi-channel command front end for the h table body.
// Per-channel FIFOs, round-robin merge into one registered issue port.
// Ports: cmd_* per-channel push (vld/rdy), iss_* issue (vld/rdy),
//        cpl_vld returns one credit, inflight count, sticky cpl_err.

package h_pkg;
  typedef logic [2:0]  opcode_t;
  typedef logic [7:0]  k_t;
  typedef logic [15:0] v_t;
  typedef struct packed {
    opcode_t op;
    k_t      k;
    v_t      v;
  } cmd_t;
endpackage

module h_bdy_fe_mc
  import h_pkg::*;
#(
  parameter int CH_N         = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int INFLIGHT_MAX = 8,
  parameter int TAG_W        = 4,
  localparam int CH_W  = $clog2(CH_N),
  localparam int CNT_W = $clog2(INFLIGHT_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH_N-1:0]        cmd_vld,
  input  opcode_t [CH_N-1:0]     cmd_opcode,
  input  k_t [CH_N-1:0]          cmd_k,
  input  v_t [CH_N-1:0]          cmd_v,
  output logic [CH_N-1:0]        cmd_rdy,
  output logic                   iss_vld,
  input  logic                   iss_rdy,
  output logic [CH_W-1:0]        iss_ch,
  output logic [TAG_W-1:0]       iss_tag,
  output opcode_t                iss_opcode,
  output k_t                     iss_k,
  output v_t                     iss_v,
  input  logic                   cpl_vld,
  output logic [CNT_W-1:0]       inflight,
  output logic                   cpl_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] IMAX = CNT_W'(INFLIGHT_MAX);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  cmd_t            mem_q [CH_N][FIFO_DEPTH];
  cmd_t            mem_d [CH_N][FIFO_DEPTH];
  logic [PW-1:0]   wp_q  [CH_N];
  logic [PW-1:0]   wp_d  [CH_N];
  logic [PW-1:0]   rp_q  [CH_N];
  logic [PW-1:0]   rp_d  [CH_N];
  logic [PW:0]     cnt_q [CH_N];
  logic [PW:0]     cnt_d [CH_N];

  logic [CH_W-1:0]  rr_q, rr_d;
  logic             vld_q, vld_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  cmd_t             out_q, out_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic             err_q, err_d;

  logic             found;
  logic [CH_W-1:0]  win;
  logic             load;
  logic             push;
  logic             pop;
  int               idx;
  cmd_t             head;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    // first non-empty channel at or after rr_q, wrapping
    for (int o = 0; o < CH_N; o++) begin
      idx = (int'(rr_q) + o) % CH_N;
      if (!found && cnt_q[idx] != '0) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end

    load = (!vld_q || iss_rdy) && found && (infl_q < IMAX);
    head = mem_q[win][rp_q[win]];

    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    pop    = 1'b0;

    for (int i = 0; i < CH_N; i++) begin
      // rdy depends only on the registered count
      cmd_rdy[i] = (cnt_q[i] != FULL_CNT);
      push = cmd_vld[i] && cmd_rdy[i];
      pop  = load && (win == CH_W'(i));
      if (push) begin
        mem_d[i][wp_q[i]] = '{op: cmd_opcode[i], k: cmd_k[i], v: cmd_v[i]};
        wp_d[i] = wp_q[i] + PW'(1);
      end
      if (pop) begin
        rp_d[i] = rp_q[i] + PW'(1);
      end
      cnt_d[i] = cnt_q[i] + (PW+1)'(push) - (PW+1)'(pop);
    end

    rr_d   = rr_q;
    vld_d  = vld_q;
    ch_d   = ch_q;
    otag_d = otag_q;
    out_d  = out_q;
    tag_d  = tag_q;

    if (load) begin
      rr_d   = (win == CH_W'(CH_N - 1)) ? '0 : win + CH_W'(1);
      vld_d  = 1'b1;
      ch_d   = win;
      otag_d = tag_q;
      out_d  = head;
      tag_d  = tag_q + TAG_W'(1);
    end else if (vld_q && iss_rdy) begin
      vld_d = 1'b0;
    end

    // a completion with nothing outstanding is dropped and flagged
    infl_d = infl_q + CNT_W'(load)
           - CNT_W'(cpl_vld && infl_q != '0);
    err_d  = err_q | (cpl_vld && infl_q == '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_N; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rr_q   <= '0;
      vld_q  <= 1'b0;
      ch_q   <= '0;
      otag_q <= '0;
      out_q  <= '0;
      tag_q  <= '0;
      infl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      vld_q  <= vld_d;
      ch_q   <= ch_d;
      otag_q <= otag_d;
      out_q  <= out_d;
      tag_q  <= tag_d;
      infl_q <= infl_d;
      err_q  <= err_d;
    end
  end

  assign iss_vld    = vld_q;
  assign iss_ch     = ch_q;
  assign iss_tag    = otag_q;
  assign iss_opcode = out_q.op;
  assign iss_k      = out_q.k;
  assign iss_v      = out_q.v;
  assign inflight   = infl_q;
  assign cpl_err    = err_q;

endmodule

// File: tb/tb_h_bdy_fe_mc.sv
// tb_h_bdy_fe_mc: directed bench for h_bdy_fe_mc.
// Hand-computed expectations for ordering, credits, tags and reset.

module tb_h_bdy_fe_mc;
  import h_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      cmd_vld;
  opcode_t [3:0]   cmd_opcode;
  k_t [3:0]        cmd_k;
  v_t [3:0]        cmd_v;
  logic [3:0]      cmd_rdy;
  logic            iss_vld;
  logic            iss_rdy;
  logic [1:0]      iss_ch;
  logic [3:0]      iss_tag;
  opcode_t         iss_opcode;
  k_t              iss_k;
  v_t              iss_v;
  logic            cpl_vld;
  logic [3:0]      inflight;
  logic            cpl_err;

  int checks = 0;
  int errors = 0;
  int n;
  int acc;
  logic a;
  k_t exp2 [8] = '{8'h00, 8'h10, 8'h20, 8'h30,
                   8'h01, 8'h11, 8'h21, 8'h31};

  always #5 clk = ~clk;

  h_bdy_fe_mc dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_vld    (cmd_vld),
    .cmd_opcode (cmd_opcode),
    .cmd_k      (cmd_k),
    .cmd_v      (cmd_v),
    .cmd_rdy    (cmd_rdy),
    .iss_vld    (iss_vld),
    .iss_rdy    (iss_rdy),
    .iss_ch     (iss_ch),
    .iss_tag    (iss_tag),
    .iss_opcode (iss_opcode),
    .iss_k      (iss_k),
    .iss_v      (iss_v),
    .cpl_vld    (cpl_vld),
    .inflight   (inflight),
    .cpl_err    (cpl_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input k_t k);
    cmd_k[ch]      = k;
    cmd_opcode[ch] = k[2:0];
    cmd_v[ch]      = {8'hA5, k};
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cmd_vld = '0;
    cpl_vld = 1'b0;
    iss_rdy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    cmd_k      = '0;
    cmd_opcode = '0;
    cmd_v      = '0;
    do_reset();
    tick();
    do_reset();

    chk("rst_vld", iss_vld, 0);
    chk("rst_infl", inflight, 0);
    chk("rst_err", cpl_err, 0);
    chk("rst_rdy", cmd_rdy, 4'hf);
    chk("rst_tag", iss_tag, 0);
    chk("rst_k", iss_k, 0);

    // single channel, 3 commands
    iss_rdy = 1'b1;
    cmd_vld = 4'b0001;
    drive(0, 8'd1);
    tick();
    chk("t1_c1_vld", iss_vld, 0);
    drive(0, 8'd2);
    tick();
    chk("t1_c2_vld", iss_vld, 1);
    chk("t1_c2_k", iss_k, 1);
    chk("t1_c2_ch", iss_ch, 0);
    chk("t1_c2_tag", iss_tag, 0);
    chk("t1_c2_op", iss_opcode, 1);
    chk("t1_c2_v", iss_v, 16'hA501);
    chk("t1_c2_infl", inflight, 1);
    drive(0, 8'd3);
    cpl_vld = 1'b1;
    tick();
    cmd_vld = '0;
    chk("t1_c3_k", iss_k, 2);
    chk("t1_c3_tag", iss_tag, 1);
    chk("t1_c3_infl", inflight, 1);
    tick();
    chk("t1_c4_vld", iss_vld, 1);
    chk("t1_c4_k", iss_k, 3);
    chk("t1_c4_tag", iss_tag, 2);
    tick();
    cpl_vld = 1'b0;
    chk("t1_c5_vld", iss_vld, 0);
    chk("t1_c5_infl", inflight, 0);
    chk("t1_c5_err", cpl_err, 0);

    // four channels, two commands each
    do_reset();
    iss_rdy = 1'b1;
    cmd_vld = 4'hf;
    for (int c = 0; c < 4; c++) drive(c, k_t'(c * 16));
    tick();
    for (int c = 0; c < 4; c++) drive(c, k_t'(c * 16 + 1));
    tick();
    cmd_vld = '0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (iss_vld && iss_rdy) begin
        if (n < 8) begin
          chk("t2_k", iss_k, exp2[n]);
          chk("t2_ch", iss_ch, exp2[n][5:4]);
          chk("t2_tag", iss_tag, n);
        end
        n++;
      end
      cpl_vld = iss_vld;
      tick();
    end
    cpl_vld = 1'b0;
    chk("t2_cnt", n, 8);
    chk("t2_infl", inflight, 0);
    chk("t2_err", cpl_err, 0);

    // backpressure and FIFO full on channel 1
    do_reset();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      cmd_vld = 4'b0010;
      drive(1, k_t'(8'h41 + acc));
      a = cmd_rdy[1];
      tick();
      if (a) acc++;
    end
    cmd_vld = '0;
    chk("t3_acc", acc, 5);
    chk("t3_rdy", cmd_rdy, 4'b1101);
    chk("t3_vld", iss_vld, 1);
    chk("t3_k", iss_k, 8'h41);
    tick();
    tick();
    chk("t3_hold_k", iss_k, 8'h41);
    chk("t3_hold_tag", iss_tag, 0);
    chk("t3_hold_ch", iss_ch, 1);
    iss_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (iss_vld) begin
        chk("t3_dk", iss_k, 8'h41 + n);
        chk("t3_dtag", iss_tag, n);
        n++;
      end
      tick();
    end
    chk("t3_dcnt", n, 5);

    // credit limit, no completions
    do_reset();
    iss_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      cmd_vld = (c < 6) ? 4'hf : 4'h0;
      for (int ch = 0; ch < 4; ch++) drive(ch, k_t'(c * 4 + ch));
      if (iss_vld) n++;
      tick();
    end
    chk("t4_cnt", n, 8);
    chk("t4_vld", iss_vld, 0);
    chk("t4_infl", inflight, 8);
    cpl_vld = 1'b1;
    tick();
    cpl_vld = 1'b0;
    chk("t4_cpl_vld", iss_vld, 0);
    chk("t4_cpl_infl", inflight, 7);
    tick();
    chk("t4_one_vld", iss_vld, 1);
    chk("t4_one_infl", inflight, 8);
    tick();
    chk("t4_stop_vld", iss_vld, 0);
    tick();
    chk("t4_stop2_vld", iss_vld, 0);
    chk("t4_stop_infl", inflight, 8);

    // spurious completion, then tag wrap
    do_reset();
    cpl_vld = 1'b1;
    tick();
    cpl_vld = 1'b0;
    chk("t5_err", cpl_err, 1);
    chk("t5_infl", inflight, 0);
    tick();
    chk("t5_sticky", cpl_err, 1);
    do_reset();
    chk("t5_clr", cpl_err, 0);
    iss_rdy = 1'b1;
    acc = 0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      cmd_vld = (acc < 17) ? 4'b1000 : 4'b0000;
      drive(3, k_t'(acc));
      a = cmd_rdy[3] && (acc < 17);
      if (iss_vld) begin
        chk("t5_tag", iss_tag, n % 16);
        chk("t5_k", iss_k, n);
        n++;
      end
      cpl_vld = iss_vld;
      tick();
      if (a) acc++;
    end
    cmd_vld = '0;
    cpl_vld = 1'b0;
    chk("t5_cnt", n, 17);
    chk("t5_err2", cpl_err, 0);

    // reset mid-operation
    do_reset();
    cmd_vld = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      drive(0, k_t'(8'h60 + c));
      tick();
    end
    cmd_vld = '0;
    tick();
    chk("t6_pre_vld", iss_vld, 1);
    chk("t6_pre_infl", inflight, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vld", iss_vld, 0);
    chk("t6_infl", inflight, 0);
    chk("t6_rdy", cmd_rdy, 4'hf);
    iss_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (iss_vld) n++;
      tick();
    end
    chk("t6_stale", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
